// File: rtl/bcd_updown_counter.sv
// Cascaded BCD up/down counter with a power-of-two tick prescaler,
// synchronous clear/load and per-digit active-low 7-segment outputs.
module bcd_updown_counter #(
   parameter int DIGITS    = 2,
   parameter int DIV_EXP   = 22,
   parameter int MAX_COUNT = 99,
   parameter int BLANK_LZ  = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  up_down,
   input  logic                  clear,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_value,
   output logic [4*DIGITS-1:0]   count_bcd,
   output logic [7*DIGITS-1:0]   seg7_out,
   output logic                  tick,
   output logic                  terminal,
   output logic                  wrap,
   output logic                  led_com
);

   localparam int CW = 4*DIGITS;

   function automatic logic [CW-1:0] f_to_bcd(input int v);
      logic [CW-1:0] r;
      int            t;
      r = '0;
      t = v;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t           = t / 10;
      end
      return r;
   endfunction

   function automatic logic [6:0] f_seg(input logic [3:0] d);
      case (d)
         4'd0:    return 7'b1000000;
         4'd1:    return 7'b1111001;
         4'd2:    return 7'b0100100;
         4'd3:    return 7'b0110000;
         4'd4:    return 7'b0011001;
         4'd5:    return 7'b0010010;
         4'd6:    return 7'b0000010;
         4'd7:    return 7'b1111000;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   localparam logic [CW-1:0] MAX_BCD = f_to_bcd(MAX_COUNT);

   logic          w_pre_full;
   logic          r_tick;
   logic          r_wrap;
   logic [CW-1:0] r_count;
   logic [CW-1:0] w_load_san;
   logic [CW-1:0] w_load_val;
   logic [CW-1:0] w_inc;
   logic [CW-1:0] w_dec;

   // With no divider the prescaler degenerates to "always full", giving a tick every cycle.
   generate
      if (DIV_EXP == 0) begin : g_nodiv
         assign w_pre_full = 1'b1;
      end else begin : g_div
         logic [DIV_EXP-1:0] r_pre;
         always_ff @(posedge clk or posedge reset) begin
            if (reset) r_pre <= '0;
            else       r_pre <= r_pre + 1'b1;
         end
         assign w_pre_full = &r_pre;
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_tick <= 1'b0;
      else       r_tick <= w_pre_full;
   end

   always_comb begin
      w_load_san = '0;
      for (int i = 0; i < DIGITS; i++)
         w_load_san[4*i +: 4] = (load_value[4*i +: 4] > 4'd9) ? 4'd0 : load_value[4*i +: 4];
      // BCD digits compare in numeric order, so a plain vector compare clamps correctly.
      w_load_val = (w_load_san > MAX_BCD) ? MAX_BCD : w_load_san;
   end

   always_comb begin
      logic c;
      logic b;
      w_inc = r_count;
      w_dec = r_count;
      c     = 1'b1;
      b     = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (c) begin
            if (r_count[4*i +: 4] == 4'd9) w_inc[4*i +: 4] = 4'd0;
            else begin
               w_inc[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
               c               = 1'b0;
            end
         end
         if (b) begin
            if (r_count[4*i +: 4] == 4'd0) w_dec[4*i +: 4] = 4'd9;
            else begin
               w_dec[4*i +: 4] = r_count[4*i +: 4] - 4'd1;
               b               = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
         r_wrap  <= 1'b0;
      end else begin
         r_wrap <= 1'b0;
         if (clear) begin
            r_count <= '0;
         end else if (load) begin
            r_count <= w_load_val;
         end else if (r_tick && enable) begin
            if (up_down) begin
               if (r_count == MAX_BCD) begin
                  r_count <= '0;
                  r_wrap  <= 1'b1;
               end else begin
                  r_count <= w_inc;
               end
            end else begin
               if (r_count == '0) begin
                  r_count <= MAX_BCD;
                  r_wrap  <= 1'b1;
               end else begin
                  r_count <= w_dec;
               end
            end
         end
      end
   end

   // Walk from the most significant digit down, tracking whether everything above is zero.
   always_comb begin
      logic w_lz;
      seg7_out = '1;
      w_lz     = 1'b1;
      for (int i = DIGITS-1; i >= 0; i--) begin
         w_lz = w_lz & (r_count[4*i +: 4] == 4'd0);
         if ((BLANK_LZ != 0) && (i > 0) && w_lz) seg7_out[7*i +: 7] = 7'b1111111;
         else                                      seg7_out[7*i +: 7] = f_seg(r_count[4*i +: 4]);
      end
   end

   assign count_bcd = r_count;
   assign tick      = r_tick;
   assign wrap      = r_wrap;
   assign terminal  = up_down ? (r_count == MAX_BCD) : (r_count == '0);
   assign led_com   = 1'b0;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed bench: a 2-digit 0..23 counter with a 4-cycle tick, plus a
// 3-digit blanking counter ticking every cycle.
module tb_bcd_updown_counter;

   localparam logic [6:0] S0 = 7'b1000000;
   localparam logic [6:0] S1 = 7'b1111001;
   localparam logic [6:0] S7 = 7'b1111000;
   localparam logic [6:0] S9 = 7'b0010000;
   localparam logic [6:0] BL = 7'b1111111;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1, en = 1'b0, ud = 1'b0, clr = 1'b0, ld = 1'b0;
   logic [7:0]  lv = '0, cnt;
   logic [13:0] seg;
   logic        tk, term, wr, lc;

   logic        rst_b = 1'b1, en_b = 1'b0, ud_b = 1'b1, clr_b = 1'b0, ld_b = 1'b0;
   logic [11:0] lv_b = '0, cnt_b;
   logic [20:0] seg_b;
   logic        tk_b, term_b, wr_b, lc_b;

   int nvec  = 0;
   int nfail = 0;

   bcd_updown_counter #(.DIGITS(2), .DIV_EXP(2), .MAX_COUNT(23), .BLANK_LZ(0)) u_a (
      .clk(clk), .reset(rst), .enable(en), .up_down(ud), .clear(clr), .load(ld),
      .load_value(lv), .count_bcd(cnt), .seg7_out(seg), .tick(tk), .terminal(term),
      .wrap(wr), .led_com(lc));

   bcd_updown_counter #(.DIGITS(3), .DIV_EXP(0), .MAX_COUNT(999), .BLANK_LZ(1)) u_b (
      .clk(clk), .reset(rst_b), .enable(en_b), .up_down(ud_b), .clear(clr_b), .load(ld_b),
      .load_value(lv_b), .count_bcd(cnt_b), .seg7_out(seg_b), .tick(tk_b), .terminal(term_b),
      .wrap(wr_b), .led_com(lc_b));

   function automatic logic [7:0] bcd2(input int e);
      return {4'(e / 10), 4'(e % 10)};
   endfunction

   // Advance DUT A to the sample point just after its next count step; n = cycles waited for tick.
   task automatic step(output int n);
      n = 0;
      while (!tk && n < 16) begin
         @(posedge clk); #1;
         n++;
      end
      @(posedge clk); #1;
   endtask

   task automatic pulse_a(input logic c, input logic l, input logic [7:0] v);
      clr = c; ld = l; lv = v;
      @(posedge clk); #1;
      clr = 1'b0; ld = 1'b0;
   endtask

   task automatic test_reset;
      #3;
      nvec++; if (cnt !== 8'h00) begin nfail++; $display("FAIL rst_count got %h want 00", cnt); end
      nvec++; if (tk !== 1'b0) begin nfail++; $display("FAIL rst_tick got %b want 0", tk); end
      nvec++; if (wr !== 1'b0) begin nfail++; $display("FAIL rst_wrap got %b want 0", wr); end
      nvec++; if (seg !== {S0, S0}) begin nfail++; $display("FAIL rst_seg got %b want %b", seg, {S0, S0}); end
      nvec++; if (term !== 1'b1) begin nfail++; $display("FAIL rst_term_down got %b want 1", term); end
      ud = 1'b1; #1;
      nvec++; if (term !== 1'b0) begin nfail++; $display("FAIL rst_term_up got %b want 0", term); end
      nvec++; if (lc !== 1'b0) begin nfail++; $display("FAIL led_com got %b want 0", lc); end
      nvec++; if (seg_b !== {BL, BL, S0}) begin nfail++; $display("FAIL rst_seg_blank got %b want %b", seg_b, {BL, BL, S0}); end
   endtask

   task automatic test_count_up;
      int n, e;
      @(posedge clk); #1;
      rst = 1'b0; en = 1'b1; ud = 1'b1;
      for (int k = 1; k <= 24; k++) begin
         step(n);
         e = k % 24;
         if (k == 1) begin
            nvec++; if (n !== 4) begin nfail++; $display("FAIL first_tick_delay got %0d want 4", n); end
            nvec++; if (tk !== 1'b0) begin nfail++; $display("FAIL tick_one_cycle got %b want 0", tk); end
         end
         nvec++; if (cnt !== bcd2(e)) begin nfail++; $display("FAIL up_count step %0d got %h want %h", k, cnt, bcd2(e)); end
         nvec++; if (wr !== (k == 24)) begin nfail++; $display("FAIL up_wrap step %0d got %b want %b", k, wr, (k == 24)); end
         nvec++; if (term !== (e == 23)) begin nfail++; $display("FAIL up_term step %0d got %b want %b", k, term, (e == 23)); end
      end
      @(posedge clk); #1;
      nvec++; if (wr !== 1'b0) begin nfail++; $display("FAIL wrap_width got %b want 0", wr); end
   endtask

   task automatic test_count_down;
      int n;
      ud = 1'b0; #1;
      nvec++; if (term !== 1'b1) begin nfail++; $display("FAIL down_term_at_00 got %b want 1", term); end
      step(n);
      nvec++; if (cnt !== 8'h23) begin nfail++; $display("FAIL down_wrap_count got %h want 23", cnt); end
      nvec++; if (wr !== 1'b1) begin nfail++; $display("FAIL down_wrap_pulse got %b want 1", wr); end
      pulse_a(1'b0, 1'b1, 8'h10);
      nvec++; if (cnt !== 8'h10) begin nfail++; $display("FAIL load_10 got %h want 10", cnt); end
      step(n);
      nvec++; if (cnt !== 8'h09) begin nfail++; $display("FAIL borrow got %h want 09", cnt); end
      nvec++; if (wr !== 1'b0) begin nfail++; $display("FAIL borrow_wrap got %b want 0", wr); end
      nvec++; if (seg !== {S0, S9}) begin nfail++; $display("FAIL seg_09 got %b want %b", seg, {S0, S9}); end
   endtask

   task automatic test_load;
      pulse_a(1'b0, 1'b1, 8'h57);
      nvec++; if (cnt !== 8'h23) begin nfail++; $display("FAIL load_clamp got %h want 23", cnt); end
      nvec++; if (wr !== 1'b0) begin nfail++; $display("FAIL load_wrap got %b want 0", wr); end
      pulse_a(1'b0, 1'b1, 8'h1A);
      nvec++; if (cnt !== 8'h10) begin nfail++; $display("FAIL load_bad_digit got %h want 10", cnt); end
      pulse_a(1'b1, 1'b1, 8'h05);
      nvec++; if (cnt !== 8'h00) begin nfail++; $display("FAIL clear_over_load got %h want 00", cnt); end
      pulse_a(1'b0, 1'b1, 8'h21);
      nvec++; if (cnt !== 8'h21) begin nfail++; $display("FAIL load_21 got %h want 21", cnt); end
      pulse_a(1'b1, 1'b0, 8'h00);
      nvec++; if (cnt !== 8'h00) begin nfail++; $display("FAIL clear got %h want 00", cnt); end
   endtask

   task automatic test_enable_reset;
      int ticks, n;
      pulse_a(1'b0, 1'b1, 8'h15);
      en = 1'b0; ud = 1'b1;
      ticks = 0;
      repeat (80) begin
         @(posedge clk); #1;
         if (tk) ticks++;
      end
      nvec++; if (ticks !== 20) begin nfail++; $display("FAIL disabled_ticks got %0d want 20", ticks); end
      nvec++; if (cnt !== 8'h15) begin nfail++; $display("FAIL disabled_hold got %h want 15", cnt); end
      en = 1'b1;
      #2 rst = 1'b1;
      #1;
      nvec++; if (cnt !== 8'h00) begin nfail++; $display("FAIL async_reset got %h want 00", cnt); end
      nvec++; if (tk !== 1'b0) begin nfail++; $display("FAIL async_reset_tick got %b want 0", tk); end
      @(posedge clk); #1;
      rst = 1'b0;
      step(n);
      nvec++; if (n !== 4) begin nfail++; $display("FAIL post_reset_tick got %0d want 4", n); end
      nvec++; if (cnt !== 8'h01) begin nfail++; $display("FAIL post_reset_step got %h want 01", cnt); end
   endtask

   task automatic test_blank_fast;
      @(posedge clk); #1;
      rst_b = 1'b0; ld_b = 1'b1; lv_b = 12'h007;
      @(posedge clk); #1;
      nvec++; if (cnt_b !== 12'h007) begin nfail++; $display("FAIL b_load_007 got %h want 007", cnt_b); end
      nvec++; if (seg_b !== {BL, BL, S7}) begin nfail++; $display("FAIL b_seg_007 got %b want %b", seg_b, {BL, BL, S7}); end
      nvec++; if (tk_b !== 1'b1) begin nfail++; $display("FAIL b_first_tick got %b want 1", tk_b); end
      lv_b = 12'h010;
      @(posedge clk); #1;
      nvec++; if (seg_b !== {BL, S1, S0}) begin nfail++; $display("FAIL b_seg_010 got %b want %b", seg_b, {BL, S1, S0}); end
      lv_b = 12'h100;
      @(posedge clk); #1;
      nvec++; if (seg_b !== {S1, S0, S0}) begin nfail++; $display("FAIL b_seg_100 got %b want %b", seg_b, {S1, S0, S0}); end
      ld_b = 1'b0; en_b = 1'b1; ud_b = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         @(posedge clk); #1;
         nvec++; if (tk_b !== 1'b1) begin nfail++; $display("FAIL b_tick cycle %0d got %b want 1", i, tk_b); end
         nvec++; if (cnt_b !== 12'h100 + 12'(i)) begin nfail++; $display("FAIL b_count cycle %0d got %h want %h", i, cnt_b, 12'h100 + 12'(i)); end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail + 1);
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_count_up();
      test_count_down();
      test_load();
      test_enable_reset();
      test_blank_fast();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
